// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: pc, one output slot, one skid entry,
// and a FETCH/DROP/IDLE request FSM toward instruction memory.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr,
  output logic [31:0] instr_add_4,
  output logic        instr_valid
);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] add4;
    logic        valid;
  } entry_t;

  typedef enum logic [1:0] {
    FETCH,
    DROP,
    IDLE
  } state_t;

  state_t      state;
  logic [31:0] pc;
  entry_t      slot;
  entry_t      skid;
  entry_t      slot_n;
  entry_t      skid_n;
  logic        take;
  logic [31:0] pc_add;
  logic [31:0] tgt;

  assign pc_add = pc + 32'd4;
  assign tgt    = {redirect_pc[31:2], 2'b00};
  assign take   = (state == FETCH) && imem_req && imem_ack;

  // Empty entries hold all-zero so the slot doubles as the nop output.
  always_comb begin
    slot_n = slot;
    skid_n = skid;
    if (!stall) begin
      slot_n = skid;
      skid_n = '0;
    end
    if (take) begin
      if (!slot_n.valid) begin
        slot_n = '{instr: imem_rdata, add4: pc_add, valid: 1'b1};
      end else begin
        skid_n = '{instr: imem_rdata, add4: pc_add, valid: 1'b1};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      slot      <= '0;
      skid      <= '0;
    end else if (redirect) begin
      slot <= '0;
      skid <= '0;
      pc   <= tgt;
      // An unacked request must finish before the new target goes out.
      if (imem_req && !imem_ack) begin
        state <= DROP;
      end else begin
        state     <= FETCH;
        imem_req  <= 1'b1;
        imem_addr <= tgt;
      end
    end else begin
      slot <= slot_n;
      skid <= skid_n;
      unique case (state)
        FETCH: begin
          if (!imem_req) begin
            imem_req  <= 1'b1;
            imem_addr <= pc;
          end else if (imem_ack) begin
            pc <= pc_add;
            if (skid_n.valid) begin
              state    <= IDLE;
              imem_req <= 1'b0;
            end else begin
              imem_addr <= pc_add;
            end
          end
        end
        DROP: begin
          if (imem_ack) begin
            state     <= FETCH;
            imem_addr <= pc;
          end
        end
        IDLE: begin
          if (!skid_n.valid) begin
            state     <= FETCH;
            imem_req  <= 1'b1;
            imem_addr <= pc;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  assign instr       = slot.instr;
  assign instr_add_4 = slot.add4;
  assign instr_valid = slot.valid;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed scenarios push
// expected instructions, a negedge monitor pops and compares.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] instr;
  logic [31:0] instr_add_4;
  logic        instr_valid;

  typedef struct {
    logic [31:0] i;
    logic [31:0] a;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  int          checks = 0;
  int          failures = 0;
  int          acks_left = 0;
  logic        p_req = 1'b0;
  logic        p_ack = 1'b0;
  logic        p_rst = 1'b1;
  logic [31:0] p_addr = 32'h0;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk),
    .reset(reset),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .stall(stall),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .instr(instr),
    .instr_add_4(instr_add_4),
    .instr_valid(instr_valid)
  );

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr ^ 32'hA5A5_A5A5;

  // Memory: acks while requested and the ack budget lasts.
  always @(posedge clk) begin
    if (imem_req && imem_ack && acks_left > 0) acks_left--;
    #2;
    imem_ack = imem_req && (acks_left > 0);
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  function automatic exp_t mk(logic [31:0] a);
    exp_t r;
    r.i = a ^ 32'hA5A5_A5A5;
    r.a = a + 32'd4;
    return r;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (instr_valid && !stall) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_instr actual=%h required=none", instr);
        end else begin
          e = q.pop_front();
          chk("instr", instr, e.i);
          chk("instr_add_4", instr_add_4, e.a);
        end
      end else if (!instr_valid) begin
        chk("nop_instr", instr, 32'h0);
        chk("nop_add4", instr_add_4, 32'h0);
      end
      chk("addr_lsb", {30'h0, imem_addr[1:0]}, 32'h0);
      if (p_req && !p_ack && !p_rst) begin
        chk("req_hold", {31'h0, imem_req}, 32'h1);
        chk("addr_hold", imem_addr, p_addr);
      end
    end
    p_req  = imem_req;
    p_ack  = imem_ack;
    p_rst  = reset;
    p_addr = imem_addr;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    acks_left = 0;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic wait_drain(string nm);
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      cyc();
      n++;
    end
    chk(nm, q.size(), 32'h0);
  endtask

  task automatic wait_valid(string nm);
    int n = 0;
    while (!instr_valid && n < 50) begin
      cyc();
      n++;
    end
    chk(nm, {31'h0, instr_valid}, 32'h1);
  endtask

  task automatic wait_addr(string nm, logic [31:0] a);
    int n = 0;
    while (!(imem_req && imem_addr == a) && n < 50) begin
      cyc();
      n++;
    end
    chk(nm, imem_addr, a);
  endtask

  initial begin
    // Reset state
    do_reset();
    reset = 1'b1;
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_add4", instr_add_4, 32'h0);
    chk("rst_valid", {31'h0, instr_valid}, 32'h0);
    reset = 1'b0;
    cyc();
    chk("first_req", {31'h0, imem_req}, 32'h1);
    chk("first_addr", imem_addr, 32'h0);

    // Streaming
    do_reset();
    acks_left = 8;
    for (int i = 0; i < 8; i++) q.push_back(mk(32'(i * 4)));
    wait_valid("s1_first_valid");
    for (int i = 0; i < 8; i++) begin
      chk("s1_valid_each_cycle", {31'h0, instr_valid}, 32'h1);
      cyc();
    end
    wait_drain("s1_drain");

    // Stall backpressure
    do_reset();
    acks_left = 6;
    for (int i = 0; i < 6; i++) q.push_back(mk(32'(i * 4)));
    wait_valid("s2_first_valid");
    stall = 1'b1;
    cyc();
    cyc();
    chk("s2_req_dropped", {31'h0, imem_req}, 32'h0);
    chk("s2_slot_held", instr, 32'h0 ^ 32'hA5A5_A5A5);
    stall = 1'b0;
    wait_drain("s2_drain");

    // Redirect while a request waits for its ack
    do_reset();
    acks_left = 4;
    for (int i = 0; i < 4; i++) q.push_back(mk(32'(i * 4)));
    wait_addr("s3_pending_10", 32'h10);
    wait_drain("s3_drain_pre");
    redirect = 1'b1;
    redirect_pc = 32'h200;
    cyc();
    redirect = 1'b0;
    chk("s3_drop_req", {31'h0, imem_req}, 32'h1);
    chk("s3_drop_addr", imem_addr, 32'h10);
    cyc();
    acks_left = 3;
    q.push_back(mk(32'h200));
    q.push_back(mk(32'h204));
    wait_addr("s3_new_addr", 32'h200);
    wait_drain("s3_drain");

    // Redirect, ack and stall on one edge
    do_reset();
    acks_left = 2;
    wait_valid("s4_first_valid");
    stall = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h300;
    cyc();
    redirect = 1'b0;
    chk("s4_valid_cleared", {31'h0, instr_valid}, 32'h0);
    chk("s4_addr", imem_addr, 32'h300);
    chk("s4_req", {31'h0, imem_req}, 32'h1);
    stall = 1'b0;
    acks_left = 1;
    q.push_back(mk(32'h300));
    wait_drain("s4_drain");

    // Address wrap, low target bits ignored
    do_reset();
    wait_addr("s5_start", 32'h0);
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    cyc();
    redirect = 1'b0;
    acks_left = 2;
    q.push_back(mk(32'hFFFF_FFFC));
    wait_drain("s5_drain");
    chk("s5_wrap_addr", imem_addr, 32'h0);
    chk("s5_wrap_req", {31'h0, imem_req}, 32'h1);

    // Reset with a request pending and the slot full
    do_reset();
    acks_left = 1;
    stall = 1'b1;
    wait_valid("s6_valid");
    reset = 1'b1;
    cyc();
    chk("s6_req", {31'h0, imem_req}, 32'h0);
    chk("s6_addr", imem_addr, 32'h0);
    chk("s6_instr", instr, 32'h0);
    chk("s6_add4", instr_add_4, 32'h0);
    chk("s6_valid", {31'h0, instr_valid}, 32'h0);
    stall = 1'b0;
    reset = 1'b0;
    wait_addr("s6_restart", 32'h0);
    repeat (4) cyc();
    chk("final_queue", q.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
